exec_alu_unit: RTL and testbench
================================

Name: exec_alu_unit

Overview:
- Registered execute-stage arithmetic block for the single-cycle-style MIPS datapath.
- Combines three functions:
  - ALU-control decode: 3-bit ALUOp plus instruction funct[3:0] produces a 4-bit operation code.
  - 32-bit ALU with zero, negative, overflow and less-than-or-equal flags.
  - Next-PC adders: PC+4 and branch target.
- All outputs are captured in one output register stage so downstream branch/jump/writeback muxing sees stable values.

Parameters:
- WIDTH, 32, datapath width; only 32 is required to work.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands/controls valid this cycle
- aluop  in  3  ALUOp {aluop2,aluop1,aluop0} from main control
- funct  in  4  instruction bits [3:0]
- a  in  32  operand A (register read data 1)
- b  in  32  operand B (post-ALUSrc mux)
- pc  in  32  current program counter
- sext_imm  in  32  sign-extended 16-bit immediate
- out_valid  out  1  registered in_valid
- gout  out  4  registered operation code
- result  out  32  registered ALU result
- zout  out  1  result == 0
- nflag  out  1  result[31]
- vflag  out  1  signed overflow
- ltoeflag  out  1  signed a <= b
- pc_plus4  out  32  pc + 4
- branch_target  out  32  pc_plus4 + (sext_imm << 2)

Behaviour:
- Reset and latency:
  - Reset is synchronous, active-high, on clk rising edge.
  - On reset, every output register is 0, including out_valid, gout and all flags.
  - Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
  - All outputs update every cycle regardless of in_valid; in_valid only propagates to out_valid.
  - rst wins over simultaneous valid input.
- ALU-control decode (aluop -> gout):
  - 000 ADD(0010)
  - 001 SUB(0110)
  - 010 R-type: decode funct as below
  - 011 OR(0001)
  - 100 NAND(0011)
  - 101 AND(0000)
  - 110 SLT(0111)
  - 111 ADD(0010)
- R-type funct -> gout:
  - 0000 ADD
  - 0010 SUB
  - 0100 AND
  - 0101 OR
  - 0110 XOR(0100)
  - 0111 NOR(1100)
  - 1010 SLT
  - 1011 NAND
  - any other funct -> ADD
- ALU ops:
  - AND a&b; OR a|b; ADD a+b; NAND ~(a&b); XOR a^b; SUB a-b; NOR ~(a|b).
  - SLT gives 1 if a<b (signed, two's complement), else 0.
  - An unused gout code gives result 0.
  - Arithmetic is modulo 2^32; no carry output.
- Flags, all computed from the same-cycle operation:
  - zout = (result == 0).
  - nflag = result[31].
  - vflag:
    - ADD: a[31]==b[31] and result[31]!=a[31].
    - SUB: a[31]!=b[31] and result[31]!=a[31].
    - All other ops: 0.
  - ltoeflag:
    - Always signed a <= b, independent of gout.
    - Computed from an internal a-b as (diff_neg XOR diff_ovf) OR (a==b).
    - Must be correct at 0x80000000 vs 0x7FFFFFFF.
- Adders:
  - Both are unsigned 32-bit with wrap-around; carry is discarded.
  - pc_plus4 = pc + 4.
  - branch_target = pc + 4 + {sext_imm[29:0], 2'b00}.
  - A negative offset gives a backward target.
  - pc = 0xFFFFFFFC gives pc_plus4 = 0.
- Implementation constraint: all arithmetic is combinational, with a single register stage at the outputs; no multicycle ops.

Test Plan:
1. Reset and latency:
   - Stimulus: hold rst 2 cycles with nonzero inputs.
   - Required: all outputs 0.
   - Stimulus: release rst, apply aluop=000, a=3, b=4, in_valid=1.
   - Required: after next edge, result=7, gout=0010, out_valid=1, zout=0.
2. Overflow:
   - ADD: aluop=000, a=0x7FFFFFFF, b=1 -> result=0x80000000, vflag=1, nflag=1, zout=0, ltoeflag=0.
   - SUB: aluop=001, a=0x80000000, b=1 -> result=0x7FFFFFFF, vflag=1, ltoeflag=1.
3. Branch compare:
   - aluop=001, a=5, b=5 -> result=0, zout=1, ltoeflag=1.
   - aluop=001, a=0xFFFFFFFF, b=0 -> ltoeflag=1, nflag=1.
4. R-type decode sweep, with a=0xF0F0F0F0, b=0xFF00FF00:
   - funct 0100 -> 0xF000F000
   - funct 0101 -> 0xFFF0FFF0
   - funct 0110 -> 0x0FF00FF0
   - funct 0111 -> 0x000F000F
   - funct 1011 -> 0x0FFF0FFF
   - funct 1010, a=0xFFFFFFFF, b=1 -> result=1
   - funct 1111 -> ADD behaviour
5. NAND-immediate:
   - Stimulus: aluop=100, a=0x0000FFFF, b=0x000000FF.
   - Required: result=0xFFFFFF00, gout=0011, nflag=1.
6. PC adders:
   - pc=0x1C, sext_imm=0xFFFFFFFF -> pc_plus4=0x20, branch_target=0x1C.
   - pc=0x8, sext_imm=2 -> pc_plus4=0xC, branch_target=0x14.
   - Assert rst mid-stream: outputs return to 0 on the same edge.

Source files
------------

// File: rtl/exec_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu_unit
// Purpose  : Registered execute-stage arithmetic block for a MIPS-style
//            datapath. Decodes ALUOp/funct into a 4-bit operation code,
//            runs the 32-bit ALU with zero/negative/overflow/less-or-equal
//            flags, and forms PC+4 and the branch target. Every output is
//            captured in a single register stage (one cycle latency).
// Ports    : clk, rst (sync, active-high)
//            in_valid, aluop[2:0], funct[3:0], a, b, pc, sext_imm  (inputs)
//            out_valid, gout[3:0], result, zout, nflag, vflag, ltoeflag,
//            pc_plus4, branch_target                               (outputs)
// Revision : 1.0 - initial release
// ============================================================================
module exec_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] sext_imm,
  output logic             out_valid,
  output logic [3:0]       gout,
  output logic [WIDTH-1:0] result,
  output logic             zout,
  output logic             nflag,
  output logic             vflag,
  output logic             ltoeflag,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target
);

  // Operation codes
  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_nand = 4'b0011;
  localparam logic [3:0] c_op_xor  = 4'b0100;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_slt  = 4'b0111;
  localparam logic [3:0] c_op_nor  = 4'b1100;

  localparam int MSB = WIDTH - 1;

  logic [3:0]       w_op;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_diff_ovf;
  logic             w_lt;
  logic             w_eq;
  logic [WIDTH-1:0] w_result;
  logic             w_vflag;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_branch_target;
  logic             w_unused_imm_hi;

  // --------------------------------------------------------------------------
  // ALU-control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_op = c_op_add;
    case (aluop)
      3'b000: w_op = c_op_add;
      3'b001: w_op = c_op_sub;
      3'b010: begin
        case (funct)
          4'b0000: w_op = c_op_add;
          4'b0010: w_op = c_op_sub;
          4'b0100: w_op = c_op_and;
          4'b0101: w_op = c_op_or;
          4'b0110: w_op = c_op_xor;
          4'b0111: w_op = c_op_nor;
          4'b1010: w_op = c_op_slt;
          4'b1011: w_op = c_op_nand;
          default: w_op = c_op_add;
        endcase
      end
      3'b011: w_op = c_op_or;
      3'b100: w_op = c_op_nand;
      3'b101: w_op = c_op_and;
      3'b110: w_op = c_op_slt;
      default: w_op = c_op_add;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shared adder/subtractor. The a-b path feeds SUB, SLT and ltoeflag, so the
  // signed compare is always available no matter which operation is chosen.
  // --------------------------------------------------------------------------
  assign w_sum      = a + b;
  assign w_diff     = a - b;
  assign w_diff_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
  // Sign of the true difference: raw sign bit corrected by overflow, which
  // keeps 0x80000000 vs 0x7FFFFFFF correct.
  assign w_lt       = w_diff[MSB] ^ w_diff_ovf;
  assign w_eq       = (a == b);

  always_comb begin
    w_result = '0;
    w_vflag  = 1'b0;
    case (w_op)
      c_op_and:  w_result = a & b;
      c_op_or:   w_result = a | b;
      c_op_add: begin
        w_result = w_sum;
        w_vflag  = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      c_op_nand: w_result = ~(a & b);
      c_op_xor:  w_result = a ^ b;
      c_op_sub: begin
        w_result = w_diff;
        w_vflag  = w_diff_ovf;
      end
      c_op_slt:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
      c_op_nor:  w_result = ~(a | b);
      default:   w_result = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-PC adders (wrap-around, carry discarded). The two top immediate bits
  // fall off the word-aligned shift.
  // --------------------------------------------------------------------------
  assign w_pc_plus4      = pc + WIDTH'(4);
  assign w_branch_target = w_pc_plus4 + {sext_imm[WIDTH-3:0], 2'b00};
  assign w_unused_imm_hi = &{1'b0, sext_imm[WIDTH-1:WIDTH-2]};

  // --------------------------------------------------------------------------
  // Output register stage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      gout          <= 4'b0000;
      result        <= '0;
      zout          <= 1'b0;
      nflag         <= 1'b0;
      vflag         <= 1'b0;
      ltoeflag      <= 1'b0;
      pc_plus4      <= '0;
      branch_target <= '0;
    end else begin
      out_valid     <= in_valid;
      gout          <= w_op;
      result        <= w_result;
      zout          <= (w_result == '0);
      nflag         <= w_result[MSB];
      vflag         <= w_vflag;
      ltoeflag      <= w_lt | w_eq;
      pc_plus4      <= w_pc_plus4;
      branch_target <= w_branch_target;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_alu_unit
// Purpose  : Self-checking bench for exec_alu_unit. Directed steps followed
//            by random operations, each compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  aluop;
  logic [3:0]  funct;
  logic [31:0] a, b, pc, sext_imm;
  logic        out_valid;
  logic [3:0]  gout;
  logic [31:0] result;
  logic        zout, nflag, vflag, ltoeflag;
  logic [31:0] pc_plus4, branch_target;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exec_alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .pc(pc), .sext_imm(sext_imm),
    .out_valid(out_valid), .gout(gout), .result(result), .zout(zout),
    .nflag(nflag), .vflag(vflag), .ltoeflag(ltoeflag),
    .pc_plus4(pc_plus4), .branch_target(branch_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: decode tables plus plain signed arithmetic.
  function automatic logic [3:0] ref_op(input logic [2:0] op, input logic [3:0] f);
    case (op)
      3'd0, 3'd7: return 4'b0010;
      3'd1: return 4'b0110;
      3'd3: return 4'b0001;
      3'd4: return 4'b0011;
      3'd5: return 4'b0000;
      3'd6: return 4'b0111;
      default: case (f)
        4'b0010: return 4'b0110;
        4'b0100: return 4'b0000;
        4'b0101: return 4'b0001;
        4'b0110: return 4'b0100;
        4'b0111: return 4'b1100;
        4'b1010: return 4'b0111;
        4'b1011: return 4'b0011;
        default: return 4'b0010;
      endcase
    endcase
  endfunction

  // Drive one operation, clock it, compare every output with the model.
  task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [3:0] f,
                      input logic [31:0] ia, input logic [31:0] ib,
                      input logic [31:0] ipc, input logic [31:0] iimm);
    logic [3:0]  e_op;
    logic [31:0] e_res, e_p4, e_bt;
    logic        e_v, e_le;
    longint      sa, sb, wide;
    rst = r; in_valid = v; aluop = op; funct = f;
    a = ia; b = ib; pc = ipc; sext_imm = iimm;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    e_op = ref_op(op, f);
    e_v  = 1'b0;
    case (e_op)
      4'b0000: e_res = ia & ib;
      4'b0001: e_res = ia | ib;
      4'b0010: begin
        wide  = sa + sb;
        e_res = wide[31:0];
        e_v   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0011: e_res = ~(ia & ib);
      4'b0100: e_res = ia ^ ib;
      4'b0110: begin
        wide  = sa - sb;
        e_res = wide[31:0];
        e_v   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0111: e_res = (sa < sb) ? 32'd1 : 32'd0;
      default: e_res = ~(ia | ib);
    endcase
    e_le = (sa <= sb);
    e_p4 = ipc + 32'd4;
    e_bt = ipc + 32'd4 + iimm * 32'd4;
    @(posedge clk);
    #1;
    if (r) begin
      e_op = 4'd0; e_res = 32'd0; e_v = 1'b0; e_le = 1'b0; e_p4 = 32'd0; e_bt = 32'd0;
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, (v & ~r)});
    chk("gout", {28'd0, gout}, {28'd0, e_op});
    chk("result", result, e_res);
    chk("zout", {31'd0, zout}, {31'd0, (!r && e_res == 32'd0)});
    chk("nflag", {31'd0, nflag}, {31'd0, e_res[31]});
    chk("vflag", {31'd0, vflag}, {31'd0, e_v});
    chk("ltoeflag", {31'd0, ltoeflag}, {31'd0, e_le});
    chk("pc_plus4", pc_plus4, e_p4);
    chk("branch_target", branch_target, e_bt);
  endtask

  initial begin
    // 1. reset with nonzero inputs held for two cycles
    step(1, 1, 3'd0, 4'd0, 32'd3, 32'd4, 32'h100, 32'd8);
    step(1, 1, 3'd1, 4'd0, 32'd9, 32'd4, 32'h200, 32'd8);
    chk("rst_result_zero", result, 32'd0);
    chk("rst_zout_zero", {31'd0, zout}, 32'd0);
    step(0, 1, 3'd0, 4'd0, 32'd3, 32'd4, 32'h0, 32'h0);
    chk("first_add", result, 32'd7);
    chk("first_gout", {28'd0, gout}, 32'h2);
    // 2. overflow
    step(0, 1, 3'd0, 4'd0, 32'h7FFFFFFF, 32'd1, 32'h0, 32'h0);
    chk("add_ovf_res", result, 32'h80000000);
    chk("add_ovf_v", {31'd0, vflag}, 32'd1);
    step(0, 1, 3'd1, 4'd0, 32'h80000000, 32'd1, 32'h0, 32'h0);
    chk("sub_ovf_res", result, 32'h7FFFFFFF);
    chk("sub_ovf_le", {31'd0, ltoeflag}, 32'd1);
    step(0, 1, 3'd1, 4'd0, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0);
    chk("ltoe_max_vs_min", {31'd0, ltoeflag}, 32'd0);
    // 3. branch compare
    step(0, 1, 3'd1, 4'd0, 32'd5, 32'd5, 32'h0, 32'h0);
    chk("beq_z", {31'd0, zout}, 32'd1);
    step(0, 0, 3'd1, 4'd0, 32'hFFFFFFFF, 32'd0, 32'h0, 32'h0);
    chk("neg_le", {31'd0, ltoeflag}, 32'd1);
    // 4. R-type sweep
    step(0, 1, 3'd2, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    chk("r_and", result, 32'hF000F000);
    step(0, 1, 3'd2, 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    chk("r_or", result, 32'hFFF0FFF0);
    step(0, 1, 3'd2, 4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    chk("r_xor", result, 32'h0FF00FF0);
    step(0, 1, 3'd2, 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    chk("r_nor", result, 32'h000F000F);
    step(0, 1, 3'd2, 4'b1011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    chk("r_nand", result, 32'h0FFF0FFF);
    step(0, 1, 3'd2, 4'b1010, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
    chk("r_slt", result, 32'd1);
    step(0, 1, 3'd2, 4'b1111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    chk("r_default_add", result, 32'hEFF1EFF0);
    step(0, 1, 3'd2, 4'b0010, 32'd10, 32'd3, 32'h0, 32'h0);
    chk("r_sub", result, 32'd7);
    // 5. NAND immediate
    step(0, 1, 3'd4, 4'd0, 32'h0000FFFF, 32'h000000FF, 32'h0, 32'h0);
    chk("nandi_res", result, 32'hFFFFFF00);
    chk("nandi_gout", {28'd0, gout}, 32'h3);
    // 6. PC adders
    step(0, 1, 3'd0, 4'd0, 32'd0, 32'd0, 32'h1C, 32'hFFFFFFFF);
    chk("bt_back", branch_target, 32'h1C);
    step(0, 1, 3'd0, 4'd0, 32'd0, 32'd0, 32'h8, 32'd2);
    chk("bt_fwd", branch_target, 32'h14);
    step(0, 1, 3'd0, 4'd0, 32'd0, 32'd0, 32'hFFFFFFFC, 32'd0);
    chk("pc_wrap", pc_plus4, 32'h0);
    // other ALUOp encodings
    step(0, 1, 3'd3, 4'd0, 32'h00F0, 32'h0F00, 32'h0, 32'h0);
    step(0, 1, 3'd5, 4'd0, 32'h00FF, 32'h0F0F, 32'h0, 32'h0);
    step(0, 1, 3'd6, 4'd0, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0);
    step(0, 1, 3'd7, 4'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
    // mid-stream reset wins over valid input
    step(1, 1, 3'd0, 4'd0, 32'h12345678, 32'h1, 32'h40, 32'h4);
    // randomized operations
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 7) == 0) rb = 32'h7FFFFFFF;
      step(($urandom_range(0, 19) == 0), 1'($urandom), 3'($urandom), 4'($urandom),
           ra, rb, $urandom, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
